uart_tx: RTL and testbench
==========================

# uart_tx

UART transmitter that serialises bytes onto the RS232 TXD pin as 8N1 frames, LSB first, at a fixed baud rate derived from the system clock. It is the transmit-side counterpart of the UART receiver. It accepts bytes from on-chip logic over a valid/ready handshake and drives a registered, glitch-free serial output intended for an OBUF.

## Interface
- CLOCK_RATE, 125_000_000: frequency of clk_tx in Hz.
- BAUD_RATE, 115_200: serial bit rate in bit/s.
- Derived local DIV = (CLOCK_RATE + BAUD_RATE/2) / BAUD_RATE, which is the clocks per bit (1085 at the defaults). The bit counter width is $clog2(DIV).
- clk_tx  in  1  transmit clock; all logic is clocked on its rising edge.
- rst_clk_tx_n  in  1  asynchronous, active-low reset.
- tx_data  in  8  byte to send; sampled only on an accept.
- tx_data_valid  in  1  the source has a byte on tx_data.
- tx_data_rdy  out  1  the block can accept a byte this cycle.
- txd_tx  out  1  serial output, driven straight from a flop; idle level is 1.
- tx_busy  out  1  a frame is in progress (state != IDLE).

## Operation
- Accept occurs on any rising edge where tx_data_valid && tx_data_rdy. The byte is copied into the internal shift register, so tx_data may change after the accept edge.
- FSM states are IDLE, START, DATA, PARITY (present only with the macro), and STOP.
- IDLE: txd_tx = 1 and tx_data_rdy = 1. On accept, go to START with the bit counter cleared.
- START: txd_tx = 0 for DIV clocks, then go to DATA with bit index 0.
- DATA: txd_tx = shift[0] for DIV clocks, then shift right. After bit index 7, go to PARITY if the macro is defined, otherwise go to STOP.
- PARITY: txd_tx = even parity (XOR of the 8 accepted bits) for DIV clocks, then go to STOP.
- STOP: txd_tx = 1 for DIV clocks. tx_data_rdy = 1 only on the final clock of STOP.
  - Accept on that final clock: go directly to START (back-to-back frames, no idle gap).
  - No accept: go to IDLE.
- A valid without ready is held off. It is neither lost nor sampled, and there is no overflow condition.
- tx_busy = 1 in every state other than IDLE, including the final STOP clock.

## Timing
- Reset values: txd_tx = 1, tx_data_rdy = 1 (state IDLE), tx_busy = 0, bit counter = 0, shift register = 0.
- Reset is asynchronous. Asserting it mid-frame forces txd_tx to 1 and the FSM to IDLE immediately. The partial frame is abandoned and nothing resumes after release.
- tx_data_rdy is a combinational decode of the registered state and counter. It does not depend on tx_data_valid, so there is no combinational valid-to-ready path.
- Latency: with accept on edge N, txd_tx falls after edge N+1. Each bit lasts exactly DIV clocks.
- Frame length is 10·DIV clocks (11·DIV with parity), measured from the first START clock to the last STOP clock.
- Back-to-back streaming gives one frame every 10·DIV clocks exactly. The next start bit follows the stop bit with zero extra cycles.
- The bit counter runs 0..DIV-1 and wraps to 0 on each bit boundary. DIV is fixed at elaboration.
- Simultaneous events:
  - Valid asserted during START/DATA/PARITY or a non-final STOP clock: ignored until the final STOP clock.
  - Reset takes priority over everything.

## Configuration
- UART_TX_PARITY_EN
  - Defined: the PARITY state is built and frames are 8E1 (start, 8 data bits, even-parity bit, stop), 11·DIV clocks long.
  - Undefined: no PARITY state and no parity logic; frames are 8N1, 10·DIV clocks long.
- The matching receiver must be built with the same setting.

## Test plan
All scenarios use CLOCK_RATE = 1_000_000 and BAUD_RATE = 100_000, giving DIV = 10.
- Reset: hold rst_clk_tx_n = 0 for 5 clocks, then release → txd_tx = 1, tx_data_rdy = 1, tx_busy = 0; the line stays high for 50 idle clocks.
- Single byte: send 0xA5 → txd_tx reads 0, 1,0,1,0,0,1,0,1, 1, each level exactly 10 clocks. The line goes low one edge after accept. tx_busy is high for 100 clocks, then rdy returns.
- Streaming: hold valid high with 0x00, 0xFF, 0x55 queued → three accepts, exactly 100 clocks apart; no idle cycle between stop and start; rdy pulses for one clock per frame.
- Held off: assert valid with 0x3C at clock 20 of a frame, then change tx_data to 0x99 at clock 40 → the byte is accepted only on the final STOP clock, and 0x99 is sent.
- Mid-frame reset: pulse reset at clock 45 of frame 0x0F → txd_tx is 1 immediately and the FSM is IDLE. A following byte 0x81 is sent as a clean frame.
- Parity: with UART_TX_PARITY_EN defined, send 0x07 then 0x03 → parity bits are 1 and 0 respectively; frames are 110 clocks long.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 RS232 transmitter, valid/ready byte input, registered TXD.
// Define UART_TX_PARITY_EN to build 8E1 frames with an even-parity bit.
module uart_tx #(
  parameter int CLOCK_RATE = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk_tx,
  input  logic       rst_clk_tx_n,
  input  logic [7:0] tx_data,
  input  logic       tx_data_valid,
  output logic       tx_data_rdy,
  output logic       txd_tx,
  output logic       tx_busy
);
  localparam int DIV = (CLOCK_RATE + BAUD_RATE / 2) / BAUD_RATE;
  localparam int CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          txd_q, txd_d;
  logic          bit_end;
  logic          accept;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (cnt_q == CNT_LAST);
  // Ready comes only from registered state, never from valid.
  assign tx_data_rdy = (state_q == IDLE) ||
                       ((state_q == STOP) && bit_end);
  assign accept  = tx_data_valid && tx_data_rdy;
  assign tx_busy = (state_q != IDLE);
  assign txd_tx  = txd_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    txd_d   = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end
    unique case (state_q)
      IDLE: begin
        txd_d = 1'b1;
      end
      START: begin
        txd_d = 1'b0;
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        txd_d = shift_q[0];
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        txd_d = par_q;
        if (bit_end) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        txd_d = 1'b1;
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Accept is only possible in IDLE or on the final STOP clock.
    if (accept) begin
      state_d = START;
      cnt_d   = '0;
      shift_d = tx_data;
`ifdef UART_TX_PARITY_EN
      par_d   = ^tx_data;
`endif
    end
  end

  always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
    if (!rst_clk_tx_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
    if (!rst_clk_tx_n) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: scoreboard bench for uart_tx at DIV = 10.
// Honours UART_TX_PARITY_EN for 11-bit frames and the parity scenario.
module tb_uart_tx;
  localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FL = NB * DIV;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       rdy;
  logic       txd;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];
  int         acc_q[$];

  uart_tx #(
    .CLOCK_RATE(1_000_000),
    .BAUD_RATE (100_000)
  ) dut (
    .clk_tx       (clk),
    .rst_clk_tx_n (rst_n),
    .tx_data      (tx_data),
    .tx_data_valid(tx_valid),
    .tx_data_rdy  (rdy),
    .txd_tx       (txd),
    .tx_busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Log the edge index of each accept, just before the edge.
  always @(negedge clk) begin
    #4;
    if (rst_n && tx_valid && rdy) acc_q.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [7:0] b, input bit keep);
    int n = 0;
    tx_data  = b;
    tx_valid = 1'b1;
    exp_q.push_back(b);
    while (rdy !== 1'b1 && n < 4 * FL) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * FL) begin
      tests++;
      fails++;
      $display("FAIL send_timeout byte %h rdy=%b want 1", b, rdy);
    end
    @(negedge clk);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic rx_frame(output logic [7:0] d, output logic p,
                          output logic ok, output int s);
    logic [NB-1:0] bits;
    int n = 0;
    bits = '0;
    ok = 1'b1;
    while (txd !== 1'b0 && n < 4 * FL) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4 * FL) ok = 1'b0;
    s = cyc;
    for (int k = 0; k < NB; k++) begin
      bits[k] = txd;
      for (int j = 1; j < DIV; j++) begin
        @(negedge clk);
        if (txd !== bits[k]) ok = 1'b0;
      end
      if (k < NB - 1) @(negedge clk);
    end
    if (bits[0] !== 1'b0 || bits[NB-1] !== 1'b1) ok = 1'b0;
    d = bits[8:1];
    p = bits[NB-2];
  endtask

  task automatic test_reset;
    int hi = 0;
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (txd !== 1'b1) begin
      fails++; $display("FAIL reset_txd got %b want 1", txd);
    end
    tests++;
    if (rdy !== 1'b1) begin
      fails++; $display("FAIL reset_rdy got %b want 1", rdy);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL reset_busy got %b want 0", busy);
    end
    repeat (50) begin
      @(negedge clk);
      if (txd === 1'b1 && busy === 1'b0) hi++;
    end
    tests++;
    if (hi !== 50) begin
      fails++; $display("FAIL reset_idle high clocks %0d want 50", hi);
    end
  endtask

  task automatic test_single_byte;
    logic [7:0] d, e;
    logic p, ok;
    int s, nb, lat;
    acc_q.delete();
    nb = 0;
    fork
      begin
        send(8'hA5, 1'b0);
        while (busy === 1'b1 && nb < 3 * FL) begin
          nb++;
          @(negedge clk);
        end
      end
      rx_frame(d, p, ok, s);
    join
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests++;
    if (!ok || d !== e) begin
      fails++; $display("FAIL single_frame got %h ok=%b want %h", d, ok, e);
    end
    lat = (acc_q.size() > 0) ? s - acc_q[0] : -1;
    tests++;
    if (lat !== 2) begin
      fails++; $display("FAIL single_latency got %0d want 2", lat);
    end
    tests++;
    if (nb !== FL) begin
      fails++; $display("FAIL single_busy clocks %0d want %0d", nb, FL);
    end
    tests++;
    if (rdy !== 1'b1) begin
      fails++; $display("FAIL single_rdy_after got %b want 1", rdy);
    end
`ifdef UART_TX_PARITY_EN
    tests++;
    if (p !== 1'b0) begin
      fails++; $display("FAIL single_parity got %b want 0", p);
    end
`endif
  endtask

  task automatic test_stream;
    logic [7:0] d[3];
    logic p[3], ok[3];
    int s[3];
    logic [7:0] e;
    acc_q.delete();
    fork
      begin
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        send(8'h55, 1'b0);
      end
      begin
        for (int k = 0; k < 3; k++) rx_frame(d[k], p[k], ok[k], s[k]);
      end
    join
    for (int k = 0; k < 3; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++;
      if (!ok[k] || d[k] !== e) begin
        fails++;
        $display("FAIL stream_frame%0d got %h ok=%b want %h", k, d[k], ok[k], e);
      end
    end
    for (int k = 1; k < 3; k++) begin
      tests++;
      if (s[k] - s[k-1] !== FL) begin
        fails++;
        $display("FAIL stream_gap%0d got %0d want %0d", k, s[k] - s[k-1], FL);
      end
    end
    tests++;
    if (acc_q.size() !== 3) begin
      fails++; $display("FAIL stream_accepts got %0d want 3", acc_q.size());
    end else begin
      tests++;
      if (acc_q[1] - acc_q[0] !== FL || acc_q[2] - acc_q[1] !== FL) begin
        fails++;
        $display("FAIL stream_acc_spacing got %0d,%0d want %0d",
                 acc_q[1] - acc_q[0], acc_q[2] - acc_q[1], FL);
      end
    end
  endtask

  task automatic test_held_off;
    logic [7:0] d[2];
    logic p[2], ok[2];
    int s[2];
    logic [7:0] e;
    acc_q.delete();
    fork
      begin
        send(8'h11, 1'b0);
        repeat (20) @(negedge clk);
        tx_data  = 8'h3C;
        tx_valid = 1'b1;
        repeat (20) @(negedge clk);
        send(8'h99, 1'b0);
      end
      begin
        for (int k = 0; k < 2; k++) rx_frame(d[k], p[k], ok[k], s[k]);
      end
    join
    for (int k = 0; k < 2; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      tests++;
      if (!ok[k] || d[k] !== e) begin
        fails++;
        $display("FAIL held_frame%0d got %h ok=%b want %h", k, d[k], ok[k], e);
      end
    end
    tests++;
    if (acc_q.size() !== 2) begin
      fails++; $display("FAIL held_accepts got %0d want 2", acc_q.size());
    end else begin
      tests++;
      if (acc_q[1] - acc_q[0] !== FL) begin
        fails++;
        $display("FAIL held_acc_time got %0d want %0d", acc_q[1] - acc_q[0], FL);
      end
    end
  endtask

  task automatic test_mid_reset;
    logic [7:0] d, e;
    logic p, ok;
    int s, hi;
    hi = 0;
    send(8'h0F, 1'b0);
    repeat (46) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (txd !== 1'b1) begin
      fails++; $display("FAIL midrst_txd got %b want 1", txd);
    end
    tests++;
    if (busy !== 1'b0) begin
      fails++; $display("FAIL midrst_busy got %b want 0", busy);
    end
    tests++;
    if (rdy !== 1'b1) begin
      fails++; $display("FAIL midrst_rdy got %b want 1", rdy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (txd === 1'b1 && busy === 1'b0) hi++;
    end
    tests++;
    if (hi !== 30) begin
      fails++; $display("FAIL midrst_no_resume high clocks %0d want 30", hi);
    end
    exp_q.delete();
    acc_q.delete();
    fork
      send(8'h81, 1'b0);
      rx_frame(d, p, ok, s);
    join
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    tests++;
    if (!ok || d !== e) begin
      fails++; $display("FAIL midrst_next_frame got %h ok=%b want %h", d, ok, e);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [7:0] d[2];
    logic p[2], ok[2];
    int s[2];
    logic [7:0] e;
    logic want_p;
    fork
      begin
        send(8'h07, 1'b1);
        send(8'h03, 1'b0);
      end
      begin
        for (int k = 0; k < 2; k++) rx_frame(d[k], p[k], ok[k], s[k]);
      end
    join
    for (int k = 0; k < 2; k++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      want_p = (k == 0) ? 1'b1 : 1'b0;
      tests++;
      if (!ok[k] || d[k] !== e || p[k] !== want_p) begin
        fails++;
        $display("FAIL parity_frame%0d got %h p=%b ok=%b want %h p=%b",
                 k, d[k], p[k], ok[k], e, want_p);
      end
    end
    tests++;
    if (s[1] - s[0] !== 110) begin
      fails++; $display("FAIL parity_len got %0d want 110", s[1] - s[0]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_byte();
    test_stream();
    test_held_off();
    test_mid_reset();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
